chan_sel_mux: RTL and testbench
===============================

CHAN_SEL_MUX -- requirements
Module: chan_sel_mux

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, 2..32.
REQ-002 Parameter DATA_W, default 8: bits per channel.
REQ-003 Derived SEL_W = max(1, clog2(N_CH)).
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset; assertion is immediate, release is synchronous to clk.
REQ-006 Port in_data, input, N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port in_valid, input, N_CH: per-channel valid.
REQ-008 Port in_ready, output, N_CH: per-channel ready, one-hot or zero.
REQ-009 Port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 Port sel, input, SEL_W: channel index used in fixed mode.
REQ-011 Port out_data, output, DATA_W: registered selected data.
REQ-012 Port out_ch, output, SEL_W: index of the channel held in out_data.
REQ-013 Port out_valid, output, 1: output holds a word.
REQ-014 Port out_ready, input, 1: downstream accepts the word.

Function
REQ-015 The output SHALL be a single-entry register; load_ok = !out_valid | out_ready.
REQ-016 In fixed mode, grant SHALL be sel when sel < N_CH and in_valid[sel]; otherwise there SHALL be no grant.
REQ-017 sel >= N_CH SHALL produce no grant; out_* SHALL hold and no input SHALL be acknowledged.
REQ-018 In round-robin mode, grant SHALL go to the first valid channel scanning rr_ptr, rr_ptr+1, ... and wrapping modulo N_CH.
REQ-019 rr_ptr SHALL become (granted+1) mod N_CH on every accepted round-robin transfer; it SHALL hold otherwise, including in fixed mode.
REQ-020 in_ready[g] SHALL be 1 only when g is granted and load_ok is 1; this path is combinational and all other bits SHALL be 0.
REQ-021 A transfer SHALL occur when in_valid[g] & in_ready[g]; out_data, out_ch and out_valid=1 SHALL load on that edge, giving 1-cycle latency.
REQ-022 If out_ready=1 with no grant, out_valid SHALL clear on the next edge.
REQ-023 Simultaneous drain and load SHALL be accepted at full throughput: one word per cycle.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_ch SHALL be stable.
REQ-025 A mode or sel change SHALL affect only the next grant decision; a word already in the register SHALL be unaffected.
REQ-026 With no valid inputs, in_ready SHALL be 0 and rr_ptr SHALL hold.

Reset
REQ-027 On rst_n=0, out_valid=0, out_data=0, out_ch=0 and rr_ptr=0 SHALL take effect asynchronously.
REQ-028 A reset mid-transfer SHALL discard the held word; in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-029 With CHAN_SEL_MUX_PARITY_EN defined, an output port out_par (1 bit) SHALL carry the registered even parity (XOR) of the loaded data word, reset to 0 and updated with out_data.
REQ-030 Without CHAN_SEL_MUX_PARITY_EN, the out_par port and its logic SHALL be absent.

Structure
REQ-031 Package chan_sel_pkg SHALL hold the mode typedef (MODE_FIXED=0, MODE_RR=1) and the SEL_W helper function.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs gnt_idx and gnt_any).

Verification
REQ-033 Fixed mode: sel=3, in_valid=8'h08, ch3=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=3, out_valid=1.
REQ-034 Out-of-range select: N_CH=6, sel=7, all valid -> in_ready=0 and out_valid stays 0.
REQ-035 Round-robin: all 8 channels valid, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles.
REQ-036 Backpressure: out_ready=0 for 4 cycles while holding 8'h3C -> out_data stable and in_ready=0; release -> next word loads on the same edge.
REQ-037 Sparse round-robin: in_valid=8'b1000_0010, rr_ptr=2 -> grant 7, then 1; rr_ptr=2 after both.
REQ-038 Reset while out_valid=1 -> out_valid=0 immediately; after release, first round-robin grant starts from channel 0.

Source files
------------

// File: rtl/chan_sel_pkg.sv
// Shared types and sizing helper for the channel-select mux.
// Optional parity output is enabled by defining CHAN_SEL_MUX_PARITY_EN.
package chan_sel_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Select width never collapses below one bit, even for two channels.
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr, wrapping modulo N_CH.
module rr_arbiter
    import chan_sel_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [N_CH-1:0]  rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Rotate so bit 0 is the channel at ptr; lowest set bit wins.
        rot     = N_CH'({req, req} >> ptr);
        off     = '0;
        gnt_any = 1'b0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                gnt_any = 1'b1;
                off     = SEL_W'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W + 1)'(N_CH))
            sum = sum - (SEL_W + 1)'(N_CH);
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/chan_sel_mux.sv
// N-channel select mux into a single-entry output register, fixed or round-robin grant.
// Define CHAN_SEL_MUX_PARITY_EN to add the registered even-parity output out_par.
module chan_sel_mux
    import chan_sel_pkg::*;
#(
    parameter int  N_CH   = 8,
    parameter int  DATA_W = 8,
    localparam int SEL_W  = sel_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
`ifdef CHAN_SEL_MUX_PARITY_EN
    output logic                   out_par,
`endif
    input  logic                   out_ready
);

    logic [DATA_W-1:0] data_q, data_d, gnt_data;
    logic [SEL_W-1:0]  ch_q, ch_d, ptr_q, ptr_d, gnt_idx, rr_idx;
    logic              valid_q, valid_d;
    logic              rr_any, fix_any, gnt_any, load_ok, xfer, rr_mode;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        rr_mode = (mode_e'(mode) == MODE_RR);
        // An out-of-range sel matches no channel, so it can never grant.
        fix_any = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (sel == SEL_W'(i)) fix_any = in_valid[i];

        gnt_any = rr_mode ? rr_any : fix_any;
        gnt_idx = rr_mode ? rr_idx : sel;
        load_ok = !valid_q || out_ready;
        xfer    = rst_n && gnt_any && load_ok;

        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready[i] = xfer;
                gnt_data    = in_data[i*DATA_W +: DATA_W];
            end
        end

        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = gnt_data;
            ch_d    = gnt_idx;
            valid_d = 1'b1;
            if (rr_mode)
                ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

`ifdef CHAN_SEL_MUX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (xfer) par_d = ^gnt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_chan_sel_mux.sv
// Randomized and directed bench for chan_sel_mux against a behavioural model.
module tb_chan_sel_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_valid = '0;
    logic [7:0]  in_ready;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [47:0] in6_data = '0;
    logic [5:0]  in6_valid = '0;
    logic [5:0]  in6_ready;
    logic [2:0]  sel6 = '0;
    logic [7:0]  out6_data;
    logic [2:0]  out6_ch;
    logic        out6_valid;
    logic        out6_ready = 1'b0;
`ifdef CHAN_SEL_MUX_PARITY_EN
    logic        out_par, out6_par;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    int         m_ch = 0;
    int         m_ptr = 0;

    always #5 clk = ~clk;

    chan_sel_mux #(.N_CH(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid),
`ifdef CHAN_SEL_MUX_PARITY_EN
        .out_par(out_par),
`endif
        .out_ready(out_ready)
    );

    chan_sel_mux #(.N_CH(6), .DATA_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in6_data), .in_valid(in6_valid),
        .in_ready(in6_ready), .mode(1'b0), .sel(sel6), .out_data(out6_data),
        .out_ch(out6_ch), .out_valid(out6_valid),
`ifdef CHAN_SEL_MUX_PARITY_EN
        .out_par(out6_par),
`endif
        .out_ready(out6_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Grant from the rules: fixed -> sel if valid; rr -> first valid scanning from m_ptr.
    function automatic int m_grant();
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < 8; k++)
            if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else begin
            int g;
            g = m_grant();
            if (g >= 0 && (!m_valid || out_ready)) begin
                m_valid = 1'b1;
                m_data  = in_data[g*8 +: 8];
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % 8;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [7:0] er;
        g  = m_grant();
        er = (rst_n && g >= 0 && (!m_valid || out_ready)) ? 8'(1 << g) : 8'h00;
        chk("m_in_ready", {24'd0, in_ready}, {24'd0, er});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("m_out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("m_out_ch", {29'd0, out_ch}, m_ch);
`ifdef CHAN_SEL_MUX_PARITY_EN
        chk("m_out_par", {31'd0, out_par}, {31'd0, ^m_data});
`endif
    end

    // Six-channel instance: out-of-range select must never grant.
    initial begin
        @(posedge rst_n);
        in6_valid = 6'h3F; sel6 = 3'd7; out6_ready = 1'b1;
        for (int k = 0; k < 6; k++) in6_data[k*8 +: 8] = 8'h70 + 8'(k);
        repeat (3) begin
            @(posedge clk); #2;
            chk("oor_in_ready", {26'd0, in6_ready}, 32'h0);
            chk("oor_out_valid", {31'd0, out6_valid}, 32'h0);
        end
        sel6 = 3'd4; #1;
        chk("n6_in_ready", {26'd0, in6_ready}, 32'h10);
        @(posedge clk); #2;
        chk("n6_out_ch", {29'd0, out6_ch}, 32'd4);
        chk("n6_out_data", {24'd0, out6_data}, 32'h74);
    end

    initial begin
        in_valid = 8'hFF;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_data", {24'd0, out_data}, 32'h0);
        chk("rst_in_ready", {24'd0, in_ready}, 32'h0);
        rst_n = 1'b1; in_valid = 8'h00;

        // Fixed select of channel 3
        @(posedge clk); #2;
        mode = 1'b0; sel = 3'd3; in_valid = 8'h08; in_data[3*8 +: 8] = 8'hA5; out_ready = 1'b1;
        @(posedge clk); #2;
        chk("fix_data", {24'd0, out_data}, 32'hA5);
        chk("fix_ch", {29'd0, out_ch}, 32'd3);
        chk("fix_valid", {31'd0, out_valid}, 32'd1);

        // Round-robin over all channels: 0..7,0,1 leaves the pointer at 2
        mode = 1'b1; in_valid = 8'hFF;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            chk("rr_seq_ch", {29'd0, out_ch}, i % 8);
            chk("rr_seq_data", {24'd0, out_data}, 32'h10 + (i % 8));
        end
        in_valid = 8'b1000_0010;
        @(posedge clk); #2;
        chk("rr_sparse_a", {29'd0, out_ch}, 32'd7);
        @(posedge clk); #2;
        chk("rr_sparse_b", {29'd0, out_ch}, 32'd1);
        in_valid = 8'hFF;
        @(posedge clk); #2;
        chk("rr_ptr_after", {29'd0, out_ch}, 32'd2);

        // Backpressure holds 3C, then releases into channel 5
        mode = 1'b0; sel = 3'd0; in_valid = 8'h01; in_data[7:0] = 8'h3C;
        @(posedge clk); #2;
        chk("bp_load", {24'd0, out_data}, 32'h3C);
        out_ready = 1'b0; in_valid = 8'hFF; sel = 3'd5; in_data[5*8 +: 8] = 8'h5A;
        repeat (4) begin
            @(posedge clk); #2;
            chk("bp_hold_data", {24'd0, out_data}, 32'h3C);
            chk("bp_in_ready", {24'd0, in_ready}, 32'h0);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", {24'd0, in_ready}, 32'h20);
        @(posedge clk); #2;
        chk("bp_next_data", {24'd0, out_data}, 32'h5A);
        chk("bp_next_ch", {29'd0, out_ch}, 32'd5);

        // Asynchronous reset while holding a word
        rst_n = 1'b0; #1;
        chk("arst_valid", {31'd0, out_valid}, 32'h0);
        chk("arst_in_ready", {24'd0, in_ready}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        @(posedge clk); #2;
        chk("arst_rr_first", {29'd0, out_ch}, 32'd0);
        chk("arst_rr_valid", {31'd0, out_valid}, 32'd1);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
